// File: rtl/sap1_pkg.sv
// Shared SAP-1 sequencer definitions: opcodes, control-word bit positions,
// named control words and the one-hot ring states.
package sap1_pkg;

   localparam int CON_W   = 12;
   localparam int T_COUNT = 6;

   localparam logic [3:0] OP_LDA = 4'b0000;
   localparam logic [3:0] OP_ADD = 4'b0001;
   localparam logic [3:0] OP_SUB = 4'b0010;
   localparam logic [3:0] OP_OUT = 4'b1110;
   localparam logic [3:0] OP_HLT = 4'b1111;

   localparam int CON_CP     = 11;
   localparam int CON_EP     = 10;
   localparam int CON_LM_BAR = 9;
   localparam int CON_CE_BAR = 8;
   localparam int CON_LI_BAR = 7;
   localparam int CON_EI_BAR = 6;
   localparam int CON_LA_BAR = 5;
   localparam int CON_EA     = 4;
   localparam int CON_SU     = 3;
   localparam int CON_EU     = 2;
   localparam int CON_LB_BAR = 1;
   localparam int CON_LO_BAR = 0;

   function automatic logic [CON_W-1:0] con_bit(input int idx);
      return 12'd1 << idx;
   endfunction

   // Every word is the idle word with its active-low strobes pulled low
   // and its active-high strobes raised.
   localparam logic [CON_W-1:0] CON_IDLE   = con_bit(CON_LM_BAR) | con_bit(CON_CE_BAR) |
                                             con_bit(CON_LI_BAR) | con_bit(CON_EI_BAR) |
                                             con_bit(CON_LA_BAR) | con_bit(CON_LB_BAR) |
                                             con_bit(CON_LO_BAR);
   localparam logic [CON_W-1:0] CON_T1     = (CON_IDLE & ~con_bit(CON_LM_BAR)) | con_bit(CON_EP);
   localparam logic [CON_W-1:0] CON_T2     = CON_IDLE | con_bit(CON_CP);
   localparam logic [CON_W-1:0] CON_T3     = CON_IDLE & ~con_bit(CON_CE_BAR) & ~con_bit(CON_LI_BAR);
   localparam logic [CON_W-1:0] CON_MAR_IR = CON_IDLE & ~con_bit(CON_LM_BAR) & ~con_bit(CON_EI_BAR);
   localparam logic [CON_W-1:0] CON_LDA_T5 = CON_IDLE & ~con_bit(CON_CE_BAR) & ~con_bit(CON_LA_BAR);
   localparam logic [CON_W-1:0] CON_ALU_T5 = CON_IDLE & ~con_bit(CON_CE_BAR) & ~con_bit(CON_LB_BAR);
   localparam logic [CON_W-1:0] CON_ADD_T6 = (CON_IDLE & ~con_bit(CON_LA_BAR)) | con_bit(CON_EU);
   localparam logic [CON_W-1:0] CON_SUB_T6 = CON_ADD_T6 | con_bit(CON_SU);
   localparam logic [CON_W-1:0] CON_OUT_T4 = (CON_IDLE & ~con_bit(CON_LO_BAR)) | con_bit(CON_EA);

   typedef enum logic [T_COUNT-1:0] {
      T1 = 6'b000001,
      T2 = 6'b000010,
      T3 = 6'b000100,
      T4 = 6'b001000,
      T5 = 6'b010000,
      T6 = 6'b100000
   } ring_state_e;

   // Last execute state that carries a non-idle word for an opcode.
   function automatic logic [T_COUNT-1:0] last_exec_state(input logic [3:0] op);
      case (op)
         OP_LDA:                 return T5;
         OP_ADD, OP_SUB, OP_HLT: return T6;
         default:                return T4;
      endcase
   endfunction

endpackage

// File: rtl/ring_counter.sv
// Six-state one-hot ring counter with synchronous active-low clear, a hold
// input that freezes the state and a restart input that forces T1.
module ring_counter
   import sap1_pkg::*;
(
   input  logic               clk,
   input  logic               clr_bar,
   input  logic               hold,
   input  logic               restart,
   output logic [T_COUNT-1:0] t
);

   logic [T_COUNT-1:0] state_reg;
   logic [T_COUNT-1:0] state_next;
   logic [T_COUNT-1:0] rotated;

   genvar gi;
   generate
      for (gi = 0; gi < T_COUNT; gi++) begin : g_rotate
         assign rotated[gi] = state_reg[(gi + T_COUNT - 1) % T_COUNT];
      end
   endgenerate

   // A corrupted (non one-hot) state self-heals to T1 instead of circulating.
   always_comb begin
      state_next = rotated;
      if (!$onehot(state_reg)) begin
         state_next = T1;
      end else if (hold) begin
         state_next = state_reg;
      end else if (restart) begin
         state_next = T1;
      end
   end

   always_ff @(posedge clk) begin
      if (!clr_bar) begin
         state_reg <= T1;
      end else begin
         state_reg <= state_next;
      end
   end

   assign t = state_reg;

endmodule

// File: rtl/controller_sequencer.sv
// SAP-1 controller-sequencer: ring counter, opcode decode to the 12-bit CON
// word and sticky halt. Define SAP1_VAR_CYCLE_EN to skip trailing idle states.
module controller_sequencer
   import sap1_pkg::*;
(
   input  logic               CLK_BAR,
   input  logic               CLR_BAR,
   input  logic [3:0]         IR_OP,
   output logic [CON_W-1:0]   CON,
   output logic [T_COUNT-1:0] T,
   output logic               HLT
);

   logic [T_COUNT-1:0] t_state;
   logic               halted_reg;
   logic               halted_next;
   logic               halt_detect;
   logic               ring_hold;
   logic               ring_restart;
   logic [CON_W-1:0]   con_word;

   assign halt_detect = !halted_reg && (t_state == T4) && (IR_OP == OP_HLT);
   assign ring_hold   = halted_reg || halt_detect;

`ifdef SAP1_VAR_CYCLE_EN
   assign ring_restart = !ring_hold && (t_state == last_exec_state(IR_OP));
`else
   assign ring_restart = 1'b0;
`endif

   ring_counter u_ring (
      .clk     (CLK_BAR),
      .clr_bar (CLR_BAR),
      .hold    (ring_hold),
      .restart (ring_restart),
      .t       (t_state)
   );

   always_comb begin
      halted_next = halted_reg;
      if (halt_detect) begin
         halted_next = 1'b1;
      end
   end

   // Clear takes precedence, so a halt seen on a clearing edge is dropped.
   always_ff @(posedge CLK_BAR) begin
      if (!CLR_BAR) begin
         halted_reg <= 1'b0;
      end else begin
         halted_reg <= halted_next;
      end
   end

   always_comb begin
      con_word = CON_IDLE;
      if (!halted_reg) begin
         case (t_state)
            T1: con_word = CON_T1;
            T2: con_word = CON_T2;
            T3: con_word = CON_T3;
            T4: begin
               case (IR_OP)
                  OP_LDA, OP_ADD, OP_SUB: con_word = CON_MAR_IR;
                  OP_OUT:                 con_word = CON_OUT_T4;
                  default:                con_word = CON_IDLE;
               endcase
            end
            T5: begin
               case (IR_OP)
                  OP_LDA:         con_word = CON_LDA_T5;
                  OP_ADD, OP_SUB: con_word = CON_ALU_T5;
                  default:        con_word = CON_IDLE;
               endcase
            end
            T6: begin
               case (IR_OP)
                  OP_ADD:  con_word = CON_ADD_T6;
                  OP_SUB:  con_word = CON_SUB_T6;
                  default: con_word = CON_IDLE;
               endcase
            end
            default: con_word = CON_IDLE;
         endcase
      end
   end

   assign CON = con_word;
   assign T   = t_state;
   assign HLT = halted_reg || halt_detect;

endmodule

// File: doc/controller_sequencer.md
# controller_sequencer

SAP-1 controller-sequencer: a six-state ring counter plus instruction decode that emits the 12-bit control word (CON) for every register in the machine. It sits directly upstream of the program counter. It drives the PC's `COUNT` (Cp) input and the PC output enable (Ep), and it sequences fetch (T1–T3) and execute (T4–T6) from the opcode nibble held in the instruction register.

## Interface
Parameters: none; the control-word width (12) and the state count (6) are fixed by the architecture.
- `CLK_BAR`  in  1  inverted system clock; all state updates on its rising edge (system-clock falling edge), the same edge the program counter uses
- `CLR_BAR`  in  1  reset, synchronous, active-low
- `IR_OP`  in  4  opcode nibble from the instruction register (upper IR nibble)
- `CON`  out  12  control word, MSB→LSB: Cp, Ep, LM_BAR, CE_BAR, LI_BAR, EI_BAR, LA_BAR, EA, SU, EU, LB_BAR, LO_BAR
- `T`  out  6  one-hot ring state, bit0 = T1 … bit5 = T6
- `HLT`  out  1  halt indication; gates the system clock externally

## Operation
- Ring counter sequence: T1→T2→…→T6→T1. Exactly one bit of `T` is set at all times.
- `CON` is a combinational function of `T`, `IR_OP` and the halt flag.
- `CON` in states not listed below = 0x3E3 (all inactive).
- Fetch (opcode-independent):
  - T1 = 0x5E3 (Ep, LM_BAR low)
  - T2 = 0xBE3 (Cp)
  - T3 = 0x263 (CE_BAR, LI_BAR low)
- Opcodes and execute words:
  - LDA = 0000: T4 0x1A3, T5 0x2C3, T6 0x3E3
  - ADD = 0001: T4 0x1A3, T5 0x2E1, T6 0x3C7
  - SUB = 0010: T4 0x1A3, T5 0x2E1, T6 0x3CF
  - OUT = 1110: T4 0x3F2, T5 0x3E3, T6 0x3E3
  - HLT = 1111: T4 0x3E3
  - any other opcode: NOP, 0x3E3 in T4–T6
- Halt:
  - When `T`=T4 and `IR_OP`=1111, `HLT`=1 combinationally in that cycle.
  - On that edge a sticky `halted` flag sets and the ring does not advance.
  - While `halted`=1: `T` frozen at T4, `CON`=0x3E3, `HLT`=1, regardless of `IR_OP`.
  - Only `CLR_BAR` low clears the flag.
- Reset: `CLR_BAR` low at an edge sets `T`=T1 and clears `halted`. Reset overrides halt and any mid-instruction state. With reset released, `CON`=0x5E3 and `HLT`=0.

## Timing
- One state per `CLK_BAR` rising edge; no wait states.
- `CON` is valid from the edge that enters a state until the next edge. Cp is high for exactly one cycle (T2) per instruction, so the PC increments once per instruction.
- Instruction latency: 6 cycles fixed (see Configuration for the variable-cycle build).
- `IR_OP` is sampled only in T4–T6. Its value in T1–T3 does not affect `CON`.
- Reset and halt detection in the same cycle: reset wins; `halted` stays 0.

## Configuration
- `SAP1_VAR_CYCLE_EN` defined:
  - The ring returns to T1 immediately after the last non-idle execute state, skipping trailing NOP states.
  - LDA: 5 cycles (T5→T1).
  - OUT and unknown opcodes: 4 cycles (T4→T1).
  - ADD and SUB: still 6 cycles.
  - HLT behaviour is unchanged.
- `SAP1_VAR_CYCLE_EN` undefined: every instruction takes exactly 6 cycles.

## Structure
- Package `sap1_pkg` holds:
  - opcode constants (`OP_LDA`, `OP_ADD`, `OP_SUB`, `OP_OUT`, `OP_HLT`)
  - CON bit-index constants
  - named control-word constants (`CON_IDLE`=0x3E3, `CON_T1`, …)
  - one-hot state constants `T1`–`T6`
- Sub-module `ring_counter`: holds the 6-bit one-hot state with synchronous active-low clear, a hold input (halt) and a restart-to-T1 input (variable-cycle). The top module holds the decode and the halt flag.

## Test plan
- Reset then LDA (`IR_OP`=0000) for 6 edges → `CON` = 5E3, BE3, 263, 1A3, 2C3, 3E3; `T` walks 0x01→0x20 and back to 0x01.
- ADD then SUB back-to-back → T6 words 0x3C7 then 0x3CF; Cp high exactly once per 6 cycles.
- OUT (1110) → T4 `CON`=0x3F2; undefined op 0101 → 0x3E3 for T4–T6.
- HLT (1111) → `HLT`=1 at T4, `T` stays 0x08 for 20 cycles with `IR_OP` toggled; `CLR_BAR` low one edge → `T`=0x01, `HLT`=0.
- `CLR_BAR` low during T5 of ADD → next state T1, `CON`=0x5E3; no partial execute word afterwards.
- `SAP1_VAR_CYCLE_EN` build: LDA, OUT, ADD sequence → T1 recurs after 5, 4 and 6 cycles respectively.
